// File: rtl/tube_owner_arbiter_pkg.sv
// Shared types and helpers for the seven-segment tube owner arbiter.
// State encodings, default hold length and byte-enable merge.
package tube_owner_arbiter_pkg;

  typedef enum logic [1:0] {
    S_CPU  = 2'd0,
    S_HOLD = 2'd1,
    S_REL  = 2'd2
  } state_e;

  localparam logic [31:0] TUBE_HOLD = 32'd50_000_000;

  function automatic logic [15:0] be_merge(
    input logic [15:0] cur,
    input logic [1:0]  be,
    input logic [15:0] wd
  );
    be_merge = cur;
    if (be[0]) be_merge[7:0]  = wd[7:0];
    if (be[1]) be_merge[15:8] = wd[15:8];
  endfunction

endpackage

// File: rtl/tube_owner_arbiter_hold.sv
// Hold timer: counts HOLD_CYC cycles after start.
// expire is high in the last cycle of the hold.
module tube_hold_timer
  import tube_owner_arbiter_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter logic [31:0] HOLD_CYC = TUBE_HOLD
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(HOLD_CYC - 32'd1);

  logic [CNT_W-1:0] cnt;
  logic             run;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      // Stop at the last count so cnt never wraps.
      if (cnt == LAST) run <= 1'b0;
      else             cnt <= cnt + CNT_W'(1);
    end
  end

  assign expire = run && (cnt == LAST);

endmodule

// File: rtl/tube_owner_arbiter.sv
// Owns tube_data: CPU register by default, debug snapshot
// preempts for a timed hold, then a forced re-request.
module tube_owner_arbiter
  import tube_owner_arbiter_pkg::*;
#(
  parameter logic [31:0] HOLD_CYC = TUBE_HOLD,
  parameter int unsigned CNT_W    = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_be,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  input  logic        dbg_req,
  input  logic [15:0] dbg_data,
  output logic        dbg_ack,
  output logic        dbg_done,
  output logic        owner,
  output logic [15:0] tube_data
);

  state_e      state_q, state_d;
  logic [15:0] cpu_q, cpu_d;
  logic [15:0] dbg_q, dbg_d;
  logic [15:0] tube_q, tube_d;
  logic        owner_q, owner_d;
  logic        ack_q, ack_d;
  logic        done_q, done_d;
  logic        start;
  logic        expire;

  tube_hold_timer #(
    .CNT_W    (CNT_W),
    .HOLD_CYC (HOLD_CYC)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .expire  (expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_CPU;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_CPU:   if (dbg_req)  state_d = S_HOLD;
      S_HOLD:  if (expire)   state_d = S_REL;
      S_REL:   if (!dbg_req) state_d = S_CPU;
      default: state_d = S_CPU;
    endcase
  end

  always_comb begin
    cpu_d   = cpu_we ? be_merge(cpu_q, cpu_be, cpu_wdata)
                     : cpu_q;
    dbg_d   = dbg_q;
    tube_d  = cpu_d;
    owner_d = 1'b0;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    start   = 1'b0;
    unique case (state_q)
      S_CPU: begin
        if (dbg_req) begin
          start   = 1'b1;
          dbg_d   = dbg_data;
          tube_d  = dbg_data;
          owner_d = 1'b1;
          ack_d   = 1'b1;
        end
      end
      S_HOLD: begin
        if (expire) begin
          done_d = 1'b1;
        end else begin
          tube_d  = dbg_q;
          owner_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_q   <= '0;
      dbg_q   <= '0;
      tube_q  <= '0;
      owner_q <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cpu_q   <= cpu_d;
      dbg_q   <= dbg_d;
      tube_q  <= tube_d;
      owner_q <= owner_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  assign cpu_rdata = cpu_q;
  assign tube_data = tube_q;
  assign owner     = owner_q;
  assign dbg_ack   = ack_q;
  assign dbg_done  = done_q;

endmodule

// File: tb/tb_tube_owner_arbiter.sv
// Scoreboard bench for tube_owner_arbiter with HOLD_CYC=4.
// Stimulus pushes expectations; monitor pops after each event.
module tb_tube_owner_arbiter;

  logic        clk;
  logic        reset_n;
  logic        cpu_we;
  logic [1:0]  cpu_be;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        dbg_req;
  logic [15:0] dbg_data;
  logic        dbg_ack;
  logic        dbg_done;
  logic        owner;
  logic [15:0] tube_data;

  typedef struct {
    string       nm;
    logic [15:0] tube;
    logic        own;
    logic        ack;
    logic        done;
    logic [15:0] rd;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  tube_owner_arbiter #(
    .HOLD_CYC (32'd4),
    .CNT_W    (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_we    (cpu_we),
    .cpu_be    (cpu_be),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .dbg_req   (dbg_req),
    .dbg_data  (dbg_data),
    .dbg_ack   (dbg_ack),
    .dbg_done  (dbg_done),
    .owner     (owner),
    .tube_data (tube_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or negedge reset_n);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (tube_data !== e.tube || owner !== e.own ||
            dbg_ack !== e.ack || dbg_done !== e.done ||
            cpu_rdata !== e.rd) begin
          miscompares++;
          $display({"FAIL %s: got tube=%h own=%b ack=%b ",
                    "done=%b rd=%h, want tube=%h own=%b ",
                    "ack=%b done=%b rd=%h"},
                   e.nm, tube_data, owner, dbg_ack,
                   dbg_done, cpu_rdata, e.tube, e.own,
                   e.ack, e.done, e.rd);
        end
      end
    end
  end

  task automatic push(
    input string nm, input logic [15:0] t,
    input logic o, input logic a, input logic d,
    input logic [15:0] r
  );
    exp_t e;
    e.nm = nm; e.tube = t; e.own = o;
    e.ack = a; e.done = d; e.rd = r;
    sb.push_back(e);
  endtask

  task automatic step(
    input string nm,
    input logic we, input logic [1:0] be,
    input logic [15:0] wd,
    input logic req, input logic [15:0] dd,
    input logic [15:0] t, input logic o,
    input logic a, input logic d,
    input logic [15:0] r
  );
    cpu_we    = we;
    cpu_be    = be;
    cpu_wdata = wd;
    dbg_req   = req;
    dbg_data  = dd;
    push(nm, t, o, a, d, r);
    @(negedge clk);
  endtask

  task automatic pulse_reset(input string nm);
    cpu_we  = 1'b0;
    dbg_req = 1'b0;
    push(nm, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin : stim
    int guard;
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    cpu_we      = 1'b0;
    cpu_be      = 2'b00;
    cpu_wdata   = 16'h0;
    dbg_req     = 1'b0;
    dbg_data    = 16'h0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    step("rst_idle", 0, 2'b00, 16'h0, 0, 16'h0,
         16'h0000, 0, 0, 0, 16'h0000);
    step("wr_1234", 1, 2'b11, 16'h1234, 0, 16'h0,
         16'h1234, 0, 0, 0, 16'h1234);
    pulse_reset("rst_async");
    step("rst_after", 0, 2'b00, 16'h0, 0, 16'h0,
         16'h0000, 0, 0, 0, 16'h0000);
    step("wr_1234b", 1, 2'b11, 16'h1234, 0, 16'h0,
         16'h1234, 0, 0, 0, 16'h1234);
    step("be_lo", 1, 2'b01, 16'hABCD, 0, 16'h0,
         16'h12CD, 0, 0, 0, 16'h12CD);
    step("be_hi", 1, 2'b10, 16'hEE00, 0, 16'h0,
         16'hEECD, 0, 0, 0, 16'hEECD);
    step("be_none", 1, 2'b00, 16'hFFFF, 0, 16'h0,
         16'hEECD, 0, 0, 0, 16'hEECD);

    step("grant", 0, 2'b00, 16'h0, 1, 16'h3000,
         16'h3000, 1, 1, 0, 16'hEECD);
    step("hold2", 0, 2'b00, 16'h0, 1, 16'hFFFF,
         16'h3000, 1, 0, 0, 16'hEECD);
    step("hold3", 0, 2'b00, 16'h0, 1, 16'h1111,
         16'h3000, 1, 0, 0, 16'hEECD);
    step("hold4", 0, 2'b00, 16'h0, 1, 16'h2222,
         16'h3000, 1, 0, 0, 16'hEECD);
    step("release", 0, 2'b00, 16'h0, 1, 16'h3333,
         16'hEECD, 0, 0, 1, 16'hEECD);
    step("starve1", 0, 2'b00, 16'h0, 1, 16'h4444,
         16'hEECD, 0, 0, 0, 16'hEECD);
    step("starve2", 0, 2'b00, 16'h0, 1, 16'h4444,
         16'hEECD, 0, 0, 0, 16'hEECD);
    step("req_low", 0, 2'b00, 16'h0, 0, 16'h0,
         16'hEECD, 0, 0, 0, 16'hEECD);

    step("regrant", 0, 2'b00, 16'h0, 1, 16'h3000,
         16'h3000, 1, 1, 0, 16'hEECD);
    step("wr_hold", 1, 2'b11, 16'h5555, 0, 16'h0,
         16'h3000, 1, 0, 0, 16'h5555);
    step("hold3b", 0, 2'b00, 16'h0, 0, 16'h0,
         16'h3000, 1, 0, 0, 16'h5555);
    step("hold4b", 0, 2'b00, 16'h0, 0, 16'h0,
         16'h3000, 1, 0, 0, 16'h5555);
    step("rel_5555", 0, 2'b00, 16'h0, 0, 16'h0,
         16'h5555, 0, 0, 1, 16'h5555);
    step("cpu_idle", 0, 2'b00, 16'h0, 0, 16'h0,
         16'h5555, 0, 0, 0, 16'h5555);

    step("grant_wr", 1, 2'b11, 16'h7777, 1, 16'h0BAD,
         16'h0BAD, 1, 1, 0, 16'h7777);
    step("hold2c", 0, 2'b00, 16'h0, 1, 16'h0,
         16'h0BAD, 1, 0, 0, 16'h7777);
    pulse_reset("rst_hold");
    step("post_rst1", 0, 2'b00, 16'h0, 0, 16'h0,
         16'h0000, 0, 0, 0, 16'h0000);
    step("post_rst2", 0, 2'b00, 16'h0, 0, 16'h0,
         16'h0000, 0, 0, 0, 16'h0000);

    step("grant2", 0, 2'b00, 16'h0, 1, 16'h0C0C,
         16'h0C0C, 1, 1, 0, 16'h0000);
    step("h2", 0, 2'b00, 16'h0, 0, 16'h0,
         16'h0C0C, 1, 0, 0, 16'h0000);
    step("h3", 0, 2'b00, 16'h0, 0, 16'h0,
         16'h0C0C, 1, 0, 0, 16'h0000);
    step("h4", 0, 2'b00, 16'h0, 0, 16'h0,
         16'h0C0C, 1, 0, 0, 16'h0000);
    step("rel_wr", 1, 2'b01, 16'h00AA, 0, 16'h0,
         16'h00AA, 0, 0, 1, 16'h00AA);
    step("idle_end", 0, 2'b00, 16'h0, 0, 16'h0,
         16'h00AA, 0, 0, 0, 16'h00AA);

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0",
               sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
